// File: rtl/rst_seq_ctrl.sv
// Reset/preset sequencer: synchronises release of the chip reset and frees each
// register domain in turn, with a four-phase soft-reset handshake that re-runs the sequence.
module rst_seq_ctrl #(
  parameter int                     NUM_DOMAINS = 4,
  parameter int                     SYNC_STAGES = 2,
  parameter int                     GAP_CYCLES  = 4,
  parameter int                     SOFT_HOLD   = 8,
  parameter logic [NUM_DOMAINS-1:0] PRESET_MASK = '0
) (
  input  logic                   clk,
  input  logic                   rn,
  input  logic                   soft_req,
  output logic                   soft_ack,
  output logic [NUM_DOMAINS-1:0] rn_out,
  output logic [NUM_DOMAINS-1:0] setn_out,
  output logic                   ready,
  output logic [2:0]             state_dbg
);

  localparam int CMAX = (GAP_CYCLES > SOFT_HOLD) ? GAP_CYCLES : SOFT_HOLD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_SYNC      = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT_HOLD = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rel_q, rel_d;
  logic                   soft_q, soft_d;
  logic                   ack_q, ack_d;
  logic                   ready_q, ready_d;
  logic                   rel_now;
  logic [NUM_DOMAINS-1:0] rn_out_q, setn_out_q;

  // Handshake: soft_req is a level request; soft_ack rises with ready at the end of a
  // soft sequence and falls once soft_req is seen low. A request is only taken in RUN with ack low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    soft_d  = soft_q;
    ack_d   = ack_q;
    ready_d = ready_q;
    rel_now = 1'b0;

    if (ack_q && !soft_req) ack_d = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_SYNC;
      ST_SYNC: begin
        if (sync_q[SYNC_STAGES-1]) begin
          rel_now = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (idx_q == IW'(NUM_DOMAINS)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          if (soft_q) begin
            ack_d  = 1'b1;
            soft_d = 1'b0;
          end
        end else begin
          rel_now = 1'b1;
        end
      end
      ST_RUN: begin
        if (soft_req && !ack_q) begin
          rel_d   = '0;
          ready_d = 1'b0;
          state_d = ST_SOFT_HOLD;
          cnt_d   = CW'(SOFT_HOLD - 1);
          idx_d   = '0;
          soft_d  = 1'b1;
        end
      end
      ST_SOFT_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rel_now = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_RESET;
    endcase

    // The last domain loads a zero gap so RUN follows it by exactly one edge.
    if (rel_now) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        if (i == int'(idx_q)) rel_d[i] = 1'b1;
      end
      if (idx_q != IW'(NUM_DOMAINS)) idx_d = idx_q + IW'(1);
      cnt_d = (int'(idx_q) == NUM_DOMAINS - 1) ? '0 : CW'(GAP_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q    <= ST_RESET;
      sync_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      rel_q      <= '0;
      soft_q     <= 1'b0;
      ack_q      <= 1'b0;
      ready_q    <= 1'b0;
      rn_out_q   <= PRESET_MASK;
      setn_out_q <= ~PRESET_MASK;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rel_q      <= rel_d;
      soft_q     <= soft_d;
      ack_q      <= ack_d;
      ready_q    <= ready_d;
      rn_out_q   <= rel_d | PRESET_MASK;
      setn_out_q <= rel_d | ~PRESET_MASK;
    end
  end

  assign rn_out    = rn_out_q;
  assign setn_out  = setn_out_q;
  assign ready     = ready_q;
  assign soft_ack  = ack_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: three configurations share clk/rn; output change events are
// checked against expected (edge, outputs) entries queued before each scenario.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rn  = 1'b0;
  logic       sr0 = 1'b0, sr1 = 1'b0, sr2 = 1'b0;
  logic       ack0, ack1, ack2, ready0, ready1, ready2;
  logic [3:0] rn_out0, setn_out0, rn_out1, setn_out1;
  logic [0:0] rn_out2, setn_out2;
  logic [2:0] dbg0, dbg1, dbg2;

  int checks = 0;
  int errors = 0;

  // entry = {edge[7:0], rn_out[3:0], setn_out[3:0], ready, soft_ack}
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  logic [17:0] exp_q2[$];

  always #5 clk = ~clk;

  rst_seq_ctrl dut0 (
    .clk(clk), .rn(rn), .soft_req(sr0), .soft_ack(ack0),
    .rn_out(rn_out0), .setn_out(setn_out0), .ready(ready0), .state_dbg(dbg0)
  );

  rst_seq_ctrl #(.PRESET_MASK(4'b1010)) dut1 (
    .clk(clk), .rn(rn), .soft_req(sr1), .soft_ack(ack1),
    .rn_out(rn_out1), .setn_out(setn_out1), .ready(ready1), .state_dbg(dbg1)
  );

  rst_seq_ctrl #(.NUM_DOMAINS(1), .GAP_CYCLES(1), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .rn(rn), .soft_req(sr2), .soft_ack(ack2),
    .rn_out(rn_out2), .setn_out(setn_out2), .ready(ready2), .state_dbg(dbg2)
  );

  function automatic logic [17:0] ev(input int e, input logic [3:0] r, input logic [3:0] s,
                                     input logic rd, input logic ak);
    logic [7:0] e8;
    e8 = e[7:0];
    return {e8, r, s, rd, ak};
  endfunction

  function automatic logic [9:0] observe(input int sel);
    case (sel)
      0:       return {rn_out0, setn_out0, ready0, ack0};
      1:       return {rn_out1, setn_out1, ready1, ack1};
      default: return {3'b111, rn_out2, 3'b111, setn_out2, ready2, ack2};
    endcase
  endfunction

  task automatic monitor(input int sel, input int n_edges);
    logic [9:0]  prev, cur;
    logic [17:0] e;
    logic [7:0]  i8;
    logic        have;
    int          left;
    prev = observe(sel);
    for (int i = 1; i <= n_edges; i++) begin
      @(posedge clk); #1;
      cur = observe(sel);
      checks++;
      if ((~cur[9:6] & ~cur[5:2]) != 4'b0000) begin
        errors++;
        $display("FAIL overlap dut%0d edge %0d: rn_out=%b setn_out=%b, required never both low",
                 sel, i, cur[9:6], cur[5:2]);
      end
      if (cur !== prev) begin
        checks++;
        have = 1'b0;
        e    = '0;
        case (sel)
          0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
          1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
          default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
        endcase
        i8 = i[7:0];
        if (!have) begin
          errors++;
          $display("FAIL unexpected_change dut%0d edge %0d: outputs=%b, required no change", sel, i, cur);
        end else if ({i8, cur} !== e) begin
          errors++;
          $display("FAIL event dut%0d: got edge %0d outputs %b, required edge %0d outputs %b",
                   sel, i, cur, e[17:10], e[9:0]);
        end
      end
      prev = cur;
    end
    case (sel)
      0:       begin left = exp_q0.size(); exp_q0.delete(); end
      1:       begin left = exp_q1.size(); exp_q1.delete(); end
      default: begin left = exp_q2.size(); exp_q2.delete(); end
    endcase
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL missing_events dut%0d: %0d expected changes not seen, required 0", sel, left);
    end
  endtask

  task automatic do_reset();
    rn  = 1'b0;
    sr0 = 1'b0; sr1 = 1'b0; sr2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_power_on0(input logic [3:0] s_done);
    exp_q0.push_back(ev(3,  4'b0001, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(7,  4'b0011, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(11, 4'b0111, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(15, 4'b1111, s_done, 1'b0, 1'b0));
    exp_q0.push_back(ev(16, 4'b1111, s_done, 1'b1, 1'b0));
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if ({rn_out0, setn_out0} !== 8'b0000_1111) begin
      errors++; $display("FAIL reset_dom dut0: got %b, required 00001111", {rn_out0, setn_out0});
    end
    if ({ready0, ack0} !== 2'b00) begin
      errors++; $display("FAIL reset_ready dut0: got %b, required 00", {ready0, ack0});
    end
    if ({rn_out1, setn_out1} !== 8'b1010_0101) begin
      errors++; $display("FAIL reset_dom dut1: got %b, required 10100101", {rn_out1, setn_out1});
    end
    if ({ready1, ack1} !== 2'b00) begin
      errors++; $display("FAIL reset_ready dut1: got %b, required 00", {ready1, ack1});
    end
    if ({rn_out2, setn_out2} !== 2'b01) begin
      errors++; $display("FAIL reset_dom dut2: got %b, required 01", {rn_out2, setn_out2});
    end
    if ({ready2, ack2} !== 2'b00) begin
      errors++; $display("FAIL reset_ready dut2: got %b, required 00", {ready2, ack2});
    end
  endtask

  task automatic test_power_on();
    do_reset();
    push_power_on0(4'b1111);
    exp_q1.push_back(ev(3,  4'b1011, 4'b0101, 1'b0, 1'b0));
    exp_q1.push_back(ev(7,  4'b1011, 4'b0111, 1'b0, 1'b0));
    exp_q1.push_back(ev(11, 4'b1111, 4'b0111, 1'b0, 1'b0));
    exp_q1.push_back(ev(15, 4'b1111, 4'b1111, 1'b0, 1'b0));
    exp_q1.push_back(ev(16, 4'b1111, 4'b1111, 1'b1, 1'b0));
    exp_q2.push_back(ev(4,  4'b1111, 4'b1111, 1'b0, 1'b0));
    exp_q2.push_back(ev(5,  4'b1111, 4'b1111, 1'b1, 1'b0));
    rn = 1'b1;
    fork
      monitor(0, 24);
      monitor(1, 24);
      monitor(2, 24);
    join
  endtask

  task automatic push_soft_seq0();
    exp_q0.push_back(ev(1,  4'b0000, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(9,  4'b0001, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(13, 4'b0011, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(17, 4'b0111, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(21, 4'b1111, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(22, 4'b1111, 4'b1111, 1'b1, 1'b1));
  endtask

  // Runs from RUN state left by test_power_on.
  task automatic test_soft_reset();
    sr0 = 1'b1;
    push_soft_seq0();
    monitor(0, 26);
    sr0 = 1'b0;
    exp_q0.push_back(ev(1, 4'b1111, 4'b1111, 1'b1, 1'b0));
    monitor(0, 3);
  endtask

  task automatic test_rn_glitch();
    do_reset();
    rn = 1'b1;
    exp_q0.push_back(ev(3, 4'b0001, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(7, 4'b0011, 4'b1111, 1'b0, 1'b0));
    monitor(0, 9);
    #1 rn = 1'b0;
    #1;
    checks += 2;
    if ({rn_out0, setn_out0, ready0, ack0} !== 10'b0000_1111_00) begin
      errors++;
      $display("FAIL glitch_async dut0: got %b, required 0000111100", {rn_out0, setn_out0, ready0, ack0});
    end
    if ({rn_out1, setn_out1, ready1} !== 9'b1010_0101_0) begin
      errors++;
      $display("FAIL glitch_async dut1: got %b, required 101001010", {rn_out1, setn_out1, ready1});
    end
    #1 rn = 1'b1;
    push_power_on0(4'b1111);
    monitor(0, 20);
  endtask

  task automatic test_back_to_back();
    do_reset();
    sr0 = 1'b1;
    rn  = 1'b1;
    push_power_on0(4'b1111);
    exp_q0.push_back(ev(17, 4'b0000, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(25, 4'b0001, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(29, 4'b0011, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(33, 4'b0111, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(37, 4'b1111, 4'b1111, 1'b0, 1'b0));
    exp_q0.push_back(ev(38, 4'b1111, 4'b1111, 1'b1, 1'b1));
    monitor(0, 50);
    sr0 = 1'b0;
    exp_q0.push_back(ev(1, 4'b1111, 4'b1111, 1'b1, 1'b0));
    monitor(0, 2);
    sr0 = 1'b1;
    push_soft_seq0();
    monitor(0, 24);
    sr0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft_reset();
    test_rn_glitch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget, required completion");
    $fatal(1);
  end

endmodule
